// File: rtl/count_pkg.sv
// Shared types and helpers for the counter monitor.
// FSM encoding, default parameters, saturating increment.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } chk_state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_CYCLES = 2;
  localparam int DEF_ERR_LIMIT   = 3;
  localparam int DEF_STAT_W      = 8;

  // Increment v, sticking at max.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max
  );
    return (v >= max) ? max : v + 32'd1;
  endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones once full.
module sat_counter
  import count_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [31:0] MAX = 32'((64'd1 << W) - 64'd1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = W'(sat_inc(32'(cnt_q), MAX));
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Monitor for a free-running up-counter.
// Locks on +1 steps, flags mismatches/wraps, faults on repeats.
module count_checker
  import count_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_CYCLES = DEF_SYNC_CYCLES,
  parameter int ERR_LIMIT   = DEF_ERR_LIMIT,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              count_valid,
  input  logic              clear,
  output logic              locked,
  output logic              mismatch,
  output logic              wrap,
  output logic              fault,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count,
  output logic [1:0]        state
);

  localparam int MW = $clog2(SYNC_CYCLES + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  chk_state_t        state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [MW-1:0]     match_q, match_d;
  logic [EW-1:0]     miss_q, miss_d;
  logic              mis_q, mis_d;
  logic              wrap_q, wrap_d;
  logic [STAT_W-1:0] wcnt_q, wcnt_d;
  logic              err_inc;

  logic [WIDTH-1:0]  expected;
  logic              is_match;

  assign expected = prev_q + WIDTH'(1);
  assign is_match = (count_in == expected);

  // All state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      mis_q   <= 1'b0;
      wrap_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      mis_q   <= mis_d;
      wrap_q  <= wrap_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next FSM state; a dropped valid means the upstream restarted.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_valid) state_d = SYNC;
        end
        SYNC: begin
          if (!count_valid) begin
            state_d = IDLE;
          end else if (is_match &&
                       match_q == MW'(SYNC_CYCLES - 1)) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (!count_valid) begin
            state_d = IDLE;
          end else if (!is_match &&
                       miss_q == EW'(ERR_LIMIT - 1)) begin
            state_d = FAULT;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: sample tracking, run counters, pulses, stats.
  always_comb begin
    prev_d  = prev_q;
    match_d = match_q;
    miss_d  = miss_q;
    mis_d   = 1'b0;
    wrap_d  = 1'b0;
    wcnt_d  = wcnt_q;
    err_inc = 1'b0;
    if (clear) begin
      prev_d  = '0;
      match_d = '0;
      miss_d  = '0;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_valid) begin
            prev_d  = count_in;
            match_d = '0;
          end
        end
        SYNC: begin
          if (!count_valid) begin
            match_d = '0;
          end else begin
            prev_d = count_in;
            if (is_match) begin
              match_d = match_q + MW'(1);
              miss_d  = '0;
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          if (!count_valid) begin
            miss_d = '0;
          end else begin
            prev_d = count_in;
            if (is_match) begin
              miss_d = '0;
              if (count_in == '0) begin
                wrap_d = 1'b1;
                wcnt_d = wcnt_q + STAT_W'(1);
              end
            end else begin
              mis_d   = 1'b1;
              err_inc = 1'b1;
              miss_d  = miss_q + EW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  sat_counter #(
    .W (STAT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (err_inc),
    .clr   (clear),
    .q     (err_count)
  );

  assign locked     = (state_q == LOCKED);
  assign fault      = (state_q == FAULT);
  assign state      = state_q;
  assign mismatch   = mis_q;
  assign wrap       = wrap_q;
  assign wrap_count = wcnt_q;

endmodule

// File: doc/count_checker.md
# count_checker

Downstream monitor for the free-running 4-bit up-counter. It samples the counter's `count` output every cycle and locks onto the increment-by-one sequence. Once locked, it flags mismatches and wraps, keeps saturating statistics, and enters a sticky fault state after repeated consecutive mismatches. This is the synthesizable, observable replacement for simulation-only counter assertions. The fault and status outputs feed the status/interrupt logic.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `SYNC_CYCLES`, 2: consecutive correct increments required to lock (≥1).
- `ERR_LIMIT`, 3: consecutive mismatches in LOCKED that trigger FAULT (≥1).
- `STAT_W`, 8: width of `err_count` and `wrap_count`.

Ports:
- `clk`, in, 1: single clock, all logic on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset; the block is in reset while `reset`=0.
- `count_in`, in, `WIDTH`: count value from the upstream counter.
- `count_valid`, in, 1: `count_in` is meaningful this cycle; upstream drives it 0 while the counter is held in reset.
- `clear`, in, 1: synchronous clear; FSM returns to IDLE, and all stats and flags return to 0.
- `locked`, out, 1: high while in LOCKED.
- `mismatch`, out, 1: one-cycle pulse on each mismatch detected in LOCKED.
- `wrap`, out, 1: one-cycle pulse on a correct max→0 step while LOCKED.
- `fault`, out, 1: sticky; high in FAULT.
- `err_count`, out, `STAT_W`: saturating mismatch count.
- `wrap_count`, out, `STAT_W`: wrap count, modulo 2^`STAT_W`.
- `state`, out, 2: FSM state, for debug.

## Operation
- Internal registers: `prev` (last valid sample), `match_run` (0..`SYNC_CYCLES`), `miss_run` (0..`ERR_LIMIT`).
- Expected value is `prev`+1 mod 2^`WIDTH`; the compare is `WIDTH` bits wide, so 15→0 is correct when `WIDTH`=4.

States:
- **IDLE (0):** on a valid sample, load `prev`, set `match_run`=0, go to SYNC.
- **SYNC (1):** on each valid sample, update `prev`.
  - Sample equals expected: increment `match_run`; when it reaches `SYNC_CYCLES`, go to LOCKED with `miss_run`=0.
  - Sample differs: set `match_run`=0 and stay in SYNC. No error is counted.
- **LOCKED (2):** on each valid sample, update `prev` to the observed value, so the block resyncs to it and errors do not cascade.
  - Match: set `miss_run`=0. If the step was max→0, pulse `wrap` and increment `wrap_count`.
  - Mismatch: pulse `mismatch`, increment `err_count` (saturating at all-ones), increment `miss_run`. When `miss_run` reaches `ERR_LIMIT`, go to FAULT.
- **FAULT (3):** `fault`=1 and `locked`=0. All samples are ignored and stats are frozen. The only exits are `clear` or `reset`.

Valid handling:
- `count_valid`=0 in SYNC or LOCKED returns the FSM to IDLE (upstream restart). No error is counted and stats are kept.
- In IDLE or FAULT, `count_valid`=0 has no effect.

Other rules:
- `clear` has priority over everything, including a valid sample in the same cycle; that sample is discarded.
- `wrap` and `mismatch` are mutually exclusive.
- `mismatch` still pulses when `err_count` is saturated.

## Timing
- Every output is registered.
- A sample taken at edge N produces `locked`, `mismatch`, `wrap`, `fault`, and counter updates after edge N, visible in cycle N+1.
- Pulses are exactly one cycle wide; back-to-back mismatches give back-to-back pulses.
- Lock latency from the first valid sample is `SYNC_CYCLES` cycles (3 samples for the default).
- Asserting `reset` at any time, including mid-cycle, forces state=IDLE and all outputs, `prev`, and the run counters to 0 immediately.
- Release of `reset` takes effect at the next rising edge.
- `clear` takes effect at the edge where it is sampled high.

## Structure
- Shared package `count_pkg`:
  - `chk_state_t` enum: IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2, FAULT=2'd3.
  - Default-parameter constants.
  - `sat_inc` function.
- One sub-module, `sat_counter` (parameter `W`; inputs `inc`, `clr`; saturating output). It is instantiated for `err_count`. `wrap_count` is a plain modulo counter in `count_checker`.

## Test plan
- Reset, then valid samples 0,1,2,3: `locked`=1 in the cycle after sample 2; `err_count`=0 and `state`=2.
- Locked, samples 14,15,0,1: `wrap` pulses once, in the cycle after sample 0; `wrap_count`=1; `mismatch` never asserts.
- Locked, samples 5,6,9,10: `mismatch` pulses after 9; `err_count`=1; still locked, because 10 = 9+1 resyncs.
- Locked, samples 3,7,2,11: three mismatch pulses; `err_count`=3, `fault`=1, `locked`=0, `state`=3. Further samples leave stats unchanged. `clear` → `state`=0, `err_count`=0, `fault`=0.
- Locked, `count_valid`=0 for one cycle: `locked`=0 the next cycle and `state`=0 with stats unchanged; relock after 3 valid samples.
- Async `reset`=0 mid-cycle while LOCKED with `err_count`=2: all outputs 0 before the next edge. Separately, `clear`=1 together with a mismatching valid sample gives no `mismatch` pulse and `err_count`=0.
